// File: rtl/bootrom_loader.sv
// Boot ROM to L2/TCDM copy engine: reads consecutive words from a synchronous
// ROM port and writes them out over a req/gnt memory write port.
module bootrom_loader #(
    parameter int ROM_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start_i,
    input  logic [ROM_ADDR_WIDTH-1:0] src_addr_i,
    input  logic [MEM_ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [ROM_ADDR_WIDTH:0]   len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      rom_cen_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_a_o,
    input  logic [DATA_WIDTH-1:0]     rom_q_i,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [2:0]                dbg_state_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [MEM_ADDR_WIDTH-1:0] STRIDE   = MEM_ADDR_WIDTH'(BE_WIDTH);
    localparam logic [ROM_ADDR_WIDTH-1:0] ROM_ONE  = ROM_ADDR_WIDTH'(1);
    localparam logic [ROM_ADDR_WIDTH:0]   IDX_ONE  = (ROM_ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_e;

    // Handshake: a write transfers on any cycle where mem_req_o & mem_gnt_i are
    // both high; once raised, req/addr/data/we/be stay frozen until that cycle.

    state_e                    r_state;
    logic [ROM_ADDR_WIDTH:0]   r_idx;
    logic [ROM_ADDR_WIDTH:0]   r_len;
    logic [ROM_ADDR_WIDTH-1:0] r_rom_a;
    logic                      r_rom_cen;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic [MEM_ADDR_WIDTH-1:0] r_next_addr;
    logic                      r_mem_req;
    logic                      r_mem_we;
    logic [BE_WIDTH-1:0]       r_mem_be;
    logic [DATA_WIDTH-1:0]     r_mem_wdata;
    logic                      r_busy;
    logic                      r_done;

    logic [ROM_ADDR_WIDTH:0]   w_idx_inc;
    logic                      w_last;

    assign w_idx_inc = r_idx + IDX_ONE;
    assign w_last    = (w_idx_inc == r_len);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_rom_a     <= '0;
            r_rom_cen   <= 1'b1;
            r_mem_addr  <= '0;
            r_next_addr <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_idx       <= '0;
                        r_len       <= len_i;
                        r_next_addr <= dst_addr_i;
                        if (len_i != '0) begin
                            r_state   <= RD;
                            r_rom_a   <= src_addr_i;
                            r_rom_cen <= 1'b0;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    r_state   <= CAP;
                    r_rom_cen <= 1'b1;
                end
                CAP: begin
                    // ROM output is valid now because the address registered last cycle.
                    r_state     <= WR;
                    r_mem_wdata <= rom_q_i;
                    r_mem_addr  <= r_next_addr;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_be    <= '1;
                end
                WR: begin
                    if (mem_gnt_i) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_next_addr <= r_next_addr + STRIDE;
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= RD;
                            r_idx     <= w_idx_inc;
                            r_rom_a   <= r_rom_a + ROM_ONE;
                            r_rom_cen <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_rom_cen <= 1'b1;
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign rom_cen_o   = r_rom_cen;
    assign rom_a_o     = r_rom_a;
    assign mem_req_o   = r_mem_req;
    assign mem_addr_o  = r_mem_addr;
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_wdata_o = r_mem_wdata;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_bootrom_loader.sv
// Directed bench for bootrom_loader: ROM model, stalling grant driver and a
// scoreboard monitor comparing every ROM read and memory write against queues.
module tb_bootrom_loader;

    logic        CLK;
    logic        RST;
    logic        start_i;
    logic [7:0]  src_addr_i;
    logic [31:0] dst_addr_i;
    logic [8:0]  len_i;
    logic        busy_o;
    logic        done_o;
    logic        rom_cen_o;
    logic [7:0]  rom_a_o;
    logic [31:0] rom_q_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [2:0]  dbg_state_o;

    bootrom_loader #(
        .ROM_ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(32)
    ) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i), .src_addr_i(src_addr_i),
        .dst_addr_i(dst_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .rom_cen_o(rom_cen_o), .rom_a_o(rom_a_o), .rom_q_i(rom_q_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ROM model: address registered on CEN low, Q valid the next cycle
    logic [31:0] rom_mem [256];
    initial rom_q_i = '0;
    always @(posedge CLK) if (!rom_cen_o) rom_q_i <= rom_mem[rom_a_o];

    // scoreboard state
    logic [63:0] exp_q[$];
    logic [7:0]  exp_rom_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_in_copy = 0;
    int          wr_total = 0;
    int          stall_word = -1;
    int          stall_left = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // grant driver: stalls a chosen word of the current copy for stall_left cycles
    initial begin
        mem_gnt_i = 1'b1;
        forever begin
            @(posedge CLK); #1;
            if (mem_req_o && wr_in_copy == stall_word && stall_left > 0) begin
                mem_gnt_i = 1'b0;
                stall_left--;
            end else begin
                mem_gnt_i = 1'b1;
            end
        end
    end

    // monitor: pops expected ROM reads and writes as the DUT presents them
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (!rom_cen_o) begin
                if (exp_rom_q.size() == 0) chk("rom_unexpected_read", {56'd0, rom_a_o}, 64'hFFFF);
                else chk("rom_addr", {56'd0, rom_a_o}, {56'd0, exp_rom_q.pop_front()});
            end
            if (mem_req_o) begin
                chk("req_attr", {59'd0, mem_we_o, mem_be_o}, {59'd0, 1'b1, 4'hF});
                chk("cen_during_req", {63'd0, rom_cen_o}, 64'd1);
                if (prev_stall) chk("stall_hold", {mem_addr_o, mem_wdata_o}, {prev_addr, prev_data});
                if (mem_gnt_i) begin
                    if (exp_q.size() == 0) chk("unexpected_write", {mem_addr_o, mem_wdata_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    else chk("write", {mem_addr_o, mem_wdata_o}, exp_q.pop_front());
                    wr_in_copy++;
                    wr_total++;
                end
            end else if (prev_stall) begin
                chk("req_withdrawn", 64'd0, 64'd1);
            end
            prev_stall = mem_req_o && !mem_gnt_i;
            prev_addr  = mem_addr_o;
            prev_data  = mem_wdata_o;
        end
    end

    task automatic push_expected(input logic [7:0] src, input logic [31:0] dst, input int len);
        logic [7:0] a;
        for (int k = 0; k < len; k++) begin
            a = src + 8'(k);
            exp_rom_q.push_back(a);
            exp_q.push_back({dst + 32'(4 * k), rom_mem[a]});
        end
    endtask

    // driver: one copy, optional stall on one word and an ignored mid-copy start
    task automatic do_copy(input string tag, input logic [7:0] src, input logic [31:0] dst,
                           input int len, input int s_word, input int s_len, input bit mid_start);
        int done_k;
        int busy_n;
        int wr0;
        done_k = 0;
        busy_n = 0;
        wr0 = wr_total;
        push_expected(src, dst, len);
        wr_in_copy = 0;
        stall_word = s_word;
        stall_left = s_len;
        @(posedge CLK); #1;
        start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = 9'(len);
        for (int k = 1; k <= 300; k++) begin
            @(posedge CLK); #1;
            start_i = mid_start && (k == 4);
            if (mid_start && k == 4) begin
                src_addr_i = 8'h80; dst_addr_i = 32'hDEAD_0000; len_i = 9'd2;
            end
            @(negedge CLK);
            if (busy_o) busy_n++;
            if (done_o) begin
                done_k = k;
                break;
            end
        end
        chk({tag, "_done_cycle"}, 64'(done_k), 64'(3 * len + 1 + s_len));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(3 * len + s_len));
        chk({tag, "_busy_at_done"}, {63'd0, busy_o}, 64'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk({tag, "_done_single"}, {62'd0, done_o, busy_o}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk({tag, "_idle_after"}, {61'd0, busy_o, done_o, mem_req_o}, 64'd0);
        end
        chk({tag, "_write_count"}, 64'(wr_total - wr0), 64'(len));
        chk({tag, "_queues_empty"}, 64'(exp_q.size() + exp_rom_q.size()), 64'd0);
        stall_word = -1;
        stall_left = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'hA5000000 | 32'(i * 32'h0101);
        rom_mem[0] = 32'h1C008537;
        rom_mem[1] = 32'h08050513;
        rom_mem[2] = 32'h00050067;
        rom_mem[3] = 32'h00000013;
        RST = 1'b1; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("reset_ctrl", {59'd0, busy_o, done_o, rom_cen_o, mem_req_o, mem_we_o}, {59'd0, 5'b00100});
        chk("reset_bus", {28'd0, mem_be_o, mem_addr_o}, 64'd0);
        chk("reset_data", {24'd0, rom_a_o, mem_wdata_o}, 64'd0);
        chk("reset_state", {61'd0, dbg_state_o}, 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        do_copy("t1_basic", 8'h00, 32'h1C00_8080, 4, -1, 0, 1'b0);
        do_copy("t2_stall", 8'h00, 32'h1C00_8080, 4, 2, 5, 1'b0);
        do_copy("t3_len0", 8'h00, 32'h1C00_8080, 0, -1, 0, 1'b0);
        do_copy("t4_midstart", 8'h00, 32'h1C00_8080, 4, -1, 0, 1'b1);

        // reset while word 1 waits for grant
        push_expected(8'h00, 32'h1C00_8080, 4);
        wr_in_copy = 0;
        stall_word = 1;
        stall_left = 50;
        @(posedge CLK); #1;
        start_i = 1'b1; src_addr_i = 8'h00; dst_addr_i = 32'h1C00_8080; len_i = 9'd4;
        @(posedge CLK); #1;
        start_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (mem_req_o && !mem_gnt_i && wr_in_copy == 1) break;
        end
        chk("t5_in_wr1", {61'd0, dbg_state_o}, 64'd3);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        exp_q.delete();
        exp_rom_q.delete();
        @(negedge CLK);
        chk("t5_abort", {60'd0, mem_req_o, rom_cen_o, busy_o, done_o}, {60'd0, 4'b0100});
        @(posedge CLK); #1;
        RST = 1'b0;
        stall_word = -1;
        stall_left = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("t5_quiet", {61'd0, busy_o, done_o, mem_req_o}, 64'd0);
        end
        do_copy("t5_recopy", 8'h00, 32'h1C00_8080, 4, -1, 0, 1'b0);

        do_copy("t6_wrap", 8'hFE, 32'h2000_0FF8, 4, -1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
